// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per stage, valid/ready with backpressure.
// Optional signed-overflow output enabled by defining CLA_PIPE_OVF_EN.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_PIPE_OVF_EN
  , output logic           ovf
`endif
);

  localparam int NBLK = WIDTH / BLOCK;

  typedef struct packed {
    logic [BLOCK:0]   c;
    logic [BLOCK-1:0] s;
  } grp_t;

  // Each carry is a flat sum-of-products over the group's g/p terms and the group carry-in.
  function automatic grp_t cla_group(input logic [BLOCK-1:0] x, input logic [BLOCK-1:0] y,
                                     input logic ci);
    grp_t             r;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic             acc;
    logic             t;
    g      = x & y;
    p      = x | y;
    r.c    = '0;
    r.c[0] = ci;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      acc = ci;
      for (int unsigned j = 0; j <= i; j++) acc = acc & p[j];
      for (int unsigned j = 0; j <= i; j++) begin
        t = g[j];
        for (int unsigned m = j + 1; m <= i; m++) t = t & p[m];
        acc = acc | t;
      end
      r.c[i+1] = acc;
    end
    r.s = x ^ y ^ r.c[BLOCK-1:0];
    return r;
  endfunction

  logic [WIDTH-1:0] s_a   [NBLK];
  logic [WIDTH-1:0] s_b   [NBLK];
  logic [WIDTH-1:0] s_sum [NBLK];
  logic             s_c   [NBLK];
  logic             s_v   [NBLK];

  logic [WIDTH-1:0] n_a   [NBLK];
  logic [WIDTH-1:0] n_b   [NBLK];
  logic [WIDTH-1:0] n_sum [NBLK];
  logic             n_c   [NBLK];
  logic             n_v   [NBLK];

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             advance;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] psum;
  logic             pc;
  grp_t             grp;
`ifdef CLA_PIPE_OVF_EN
  logic             n_ovf;
  logic             ovf_q;
`endif

  assign b_eff    = b ^ {WIDTH{sub}};
  assign c0       = cin ^ sub;
  assign advance  = !s_v[NBLK-1] || out_ready;
  assign in_ready = advance;

  // Stage k consumes slice k of the operands carried along from stage k-1.
  always_comb begin
    opa  = '0;
    opb  = '0;
    psum = '0;
    pc   = 1'b0;
    grp  = '0;
`ifdef CLA_PIPE_OVF_EN
    n_ovf = 1'b0;
`endif
    for (int unsigned k = 0; k < NBLK; k++) begin
      if (k == 0) begin
        opa    = a;
        opb    = b_eff;
        psum   = '0;
        pc     = c0;
        n_v[k] = in_valid;
      end else begin
        opa    = s_a[k-1];
        opb    = s_b[k-1];
        psum   = s_sum[k-1];
        pc     = s_c[k-1];
        n_v[k] = s_v[k-1];
      end
      grp = cla_group(opa[k*BLOCK +: BLOCK], opb[k*BLOCK +: BLOCK], pc);
      n_a[k]   = opa;
      n_b[k]   = opb;
      n_sum[k] = psum;
      n_sum[k][k*BLOCK +: BLOCK] = grp.s;
      n_c[k]   = grp.c[BLOCK];
`ifdef CLA_PIPE_OVF_EN
      if (k == NBLK - 1) n_ovf = grp.c[BLOCK-1] ^ grp.c[BLOCK];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NBLK; k++) begin
        s_a[k]   <= '0;
        s_b[k]   <= '0;
        s_sum[k] <= '0;
        s_c[k]   <= 1'b0;
        s_v[k]   <= 1'b0;
      end
`ifdef CLA_PIPE_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (advance) begin
      for (int unsigned k = 0; k < NBLK; k++) begin
        s_a[k]   <= n_a[k];
        s_b[k]   <= n_b[k];
        s_sum[k] <= n_sum[k];
        s_c[k]   <= n_c[k];
        s_v[k]   <= n_v[k];
      end
`ifdef CLA_PIPE_OVF_EN
      ovf_q <= n_ovf;
`endif
    end
  end

  assign out_valid = s_v[NBLK-1];
  assign sum       = s_sum[NBLK-1];
  assign cout      = s_c[NBLK-1];
`ifdef CLA_PIPE_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
